// File: rtl/tts_pkg.sv
// Shared types and sizing helpers for the truth-table sequencer.
// State encoding, vector count and mismatch-counter width.
package tts_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam int N_IN_DEF = 3;

    function automatic int nvec(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int cnt_w(input int n_in);
        return $clog2((1 << n_in) + 1);
    endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Host-side bundle of the truth-table sequencer.
// master = host/testbench, slave = sequencer.
interface truth_table_sequencer_if
    import tts_pkg::*;
#(
    parameter int N_IN = N_IN_DEF
) ();

    localparam int NVEC = nvec(N_IN);
    localparam int CW   = cnt_w(N_IN);

    logic            start;
    logic [NVEC-1:0] expected;
    logic [NVEC-1:0] care_mask;
    logic            busy;
    logic            done;
    logic [NVEC-1:0] result;
    logic            pass;
    logic [CW-1:0]   mismatch_cnt;

    modport master (
        output start, expected, care_mask,
        input  busy, done, result, pass, mismatch_cnt
    );

    modport slave (
        input  start, expected, care_mask,
        output busy, done, result, pass, mismatch_cnt
    );

endinterface

// File: rtl/tts_settle_timer.sv
// Settle-window countdown for the truth-table sequencer.
// load presets SETTLE-1; expired is high on the last settle cycle.
module tts_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [W-1:0] cnt;

    // Preset on load, count down while the settle state is active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(SETTLE - 1);
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Exhaustive stimulus sweep of a small logic function with
// observed-vs-expected truth table comparison under a care mask.
module truth_table_sequencer
    import tts_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    truth_table_sequencer_if.slave  host,
    input  logic                    p_in,
    output logic [N_IN-1:0]         vec_out
);

    localparam int NVEC = nvec(N_IN);
    localparam int CW   = cnt_w(N_IN);

    state_t          state;
    state_t          state_nxt;
    logic [NVEC-1:0] exp_q;
    logic [NVEC-1:0] care_q;
    logic [NVEC-1:0] result_q;
    logic [CW-1:0]   cnt_q;
    logic            pass_q;
    logic            tmr_load;
    logic            tmr_en;
    logic            tmr_exp;
    logic            last_vec;
    logic            hit;

    assign last_vec = (vec_out == N_IN'(NVEC - 1));
    assign hit      = care_q[vec_out] && (p_in != exp_q[vec_out]);

    generate
        if (SETTLE > 0) begin : g_tmr
            tts_settle_timer #(
                .SETTLE (SETTLE)
            ) u_tmr (
                .clk     (clk),
                .rst     (rst),
                .load    (tmr_load),
                .en      (tmr_en),
                .expired (tmr_exp)
            );
        end else begin : g_no_tmr
            logic unused_tmr;
            assign unused_tmr = &{1'b0, tmr_load, tmr_en};
            assign tmr_exp    = 1'b1;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and settle timer control
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (host.start) begin
                    state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                tmr_load  = 1'b1;
                state_nxt = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
            end
            S_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_exp) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                state_nxt = last_vec ? S_DONE : S_DRIVE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the job on start, record samples and tally cared mismatches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q    <= '0;
            care_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            pass_q   <= 1'b0;
            vec_out  <= '0;
        end else if (state == S_IDLE) begin
            if (host.start) begin
                exp_q    <= host.expected;
                care_q   <= host.care_mask;
                result_q <= '0;
                cnt_q    <= '0;
                pass_q   <= 1'b0;
                vec_out  <= '0;
            end
        end else if (state == S_SAMPLE) begin
            result_q[vec_out] <= p_in;
            if (hit) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (last_vec) begin
                // final sample folded in so pass is valid in DONE
                pass_q <= (cnt_q == '0) && !hit;
            end else begin
                vec_out <= vec_out + 1'b1;
            end
        end
    end

    assign host.busy         = (state != S_IDLE);
    assign host.done         = (state == S_DONE);
    assign host.result       = result_q;
    assign host.pass         = pass_q;
    assign host.mismatch_cnt = cnt_q;

endmodule
